// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and the transmit state encoding.
// The RX side imports the same package so both ends agree on the defaults.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Host-side byte handshake into the UART transmitter.
//
// Handshake: a byte moves on every rising clk edge where tx_valid and
// tx_ready are both high. The source holds tx_data/tx_valid stable until
// that edge; the sink never makes tx_ready depend on tx_valid.
interface uart_tx_ctrl_if #(
    parameter int DATA_BITS = uart_pkg::UART_DATA_BITS
) ();

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_bit_timer.sv
// Counts baud ticks and flags the tick that closes one serial bit.
// Held at zero while clear is high so every bit starts on a fresh count.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic baud_tick,
    output logic bit_end
);

    localparam int              CW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0]   LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] tick_cnt;

    // Tick counter: advances on baud ticks only, wraps after the last tick of a bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (clear) begin
            tick_cnt <= '0;
        end else if (baud_tick) begin
            tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;
        end
    end

    assign bit_end = !clear && baud_tick && (tick_cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts one word per handshake, owns the baud
// generator enable and shifts start, data (LSB first), optional parity and
// stop bits onto tx_out. Every output comes straight from a flop.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_ctrl_if.slave host,
    input  logic          baud_tick,
    output logic          baud_en,
    output logic          tx_out,
    output logic          tx_busy,
    output logic          tx_done,
    output tx_state_t     state_dbg
);

    localparam int             BCW       = $clog2(DATA_BITS);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
    localparam logic           ODD_BIT   = (PARITY_ODD != 0);
    localparam logic           LAST_STOP = (STOP_BITS == 2);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 ready_q, ready_d;
    logic                 tx_out_d, baud_en_d, busy_d, done_d;
    logic                 bit_end;
    logic                 timer_clear;

    // Ticks are meaningless outside a frame, including the handshake cycle.
    assign timer_clear   = (state_q == IDLE);
    assign host.tx_ready = ready_q;
    assign state_dbg     = state_q;

    uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (timer_clear),
        .baud_tick (baud_tick),
        .bit_end   (bit_end)
    );

    // State and output registers; reset aborts any frame with the line high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            ready_q    <= 1'b1;
            tx_out     <= 1'b1;
            baud_en    <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            ready_q    <= ready_d;
            tx_out     <= tx_out_d;
            baud_en    <= baud_en_d;
            tx_busy    <= busy_d;
            tx_done    <= done_d;
        end
    end

    // Next state and next output values; tx_out is updated on the same edge
    // that enters a state so each bit lasts exactly one bit period.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        ready_d    = ready_q;
        tx_out_d   = tx_out;
        baud_en_d  = baud_en;
        busy_d     = tx_busy;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (host.tx_valid && ready_q) begin
                    state_d    = START;
                    shift_d    = host.tx_data;
                    parity_d   = (^host.tx_data) ^ ODD_BIT;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    ready_d    = 1'b0;
                    tx_out_d   = 1'b0;
                    baud_en_d  = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d  = DATA;
                    tx_out_d = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_d  = PARITY;
                            tx_out_d = parity_q;
                        end else begin
                            state_d  = STOP;
                            tx_out_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_out_d  = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d  = STOP;
                    tx_out_d = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d   = IDLE;
                        ready_d   = 1'b1;
                        baud_en_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                ready_d   = 1'b1;
                tx_out_d  = 1'b1;
                baud_en_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four instances (8N1, 8E1, 8O1, 8N2) driven by a
// behavioural baud generator; expected frames come from a bit-list model.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int NI = 4;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    bit   clk_en = 1'b0;
    logic reset  = 1'b1;

    always #5 if (clk_en) clk = ~clk;

    // ---------------- per-instance signals ----------------
    logic [7:0] data_r  [NI];
    logic       valid_r [NI];
    logic       ready_w [NI];
    logic       en_w    [NI];
    logic       tick_w  [NI];
    logic       out_w   [NI];
    logic       busy_w  [NI];
    logic       done_w  [NI];
    tx_state_t  state_w [NI];

    int tick_div = 4;   // clocks per baud tick of the behavioural generator

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_ctrl_if #(.DATA_BITS(8)) host_if ();

        assign host_if.tx_data  = data_r[g];
        assign host_if.tx_valid = valid_r[g];
        assign ready_w[g]       = host_if.tx_ready;

        uart_tx_ctrl #(
            .DATA_BITS  (8),
            .PARITY_EN  ((g == 1 || g == 2) ? 1 : 0),
            .PARITY_ODD ((g == 2) ? 1 : 0),
            .STOP_BITS  ((g == 3) ? 2 : 1),
            .OVERSAMPLE (16)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .host      (host_if),
            .baud_tick (tick_w[g]),
            .baud_en   (en_w[g]),
            .tx_out    (out_w[g]),
            .tx_busy   (busy_w[g]),
            .tx_done   (done_w[g]),
            .state_dbg (state_w[g])
        );

        // Baud generator model: count cleared while disabled, tick every tick_div clocks.
        int tick_cnt = 0;
        always @(posedge clk) begin
            if (en_w[g] !== 1'b1)              tick_cnt <= 0;
            else if (tick_cnt == tick_div - 1) tick_cnt <= 0;
            else                               tick_cnt <= tick_cnt + 1;
        end
        assign tick_w[g] = (en_w[g] === 1'b1) && (tick_cnt == tick_div - 1);
    end

    // ---------------- configuration of each instance ----------------
    function automatic bit cfg_par_en(input int i);
        return (i == 1 || i == 2);
    endfunction

    function automatic bit cfg_odd(input int i);
        return (i == 2);
    endfunction

    function automatic int cfg_stop(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop 1s.
    function automatic void build_frame(input int inst, input logic [7:0] d);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int b = 0; b < 8; b++) exp_q.push_back(d[b]);
        if (cfg_par_en(inst)) exp_q.push_back((^d) ^ cfg_odd(inst));
        for (int s = 0; s < cfg_stop(inst); s++) exp_q.push_back(1'b1);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_frame(input int inst, input logic [7:0] d, input bit hold);
        int budget = 0;
        while (ready_w[inst] !== 1'b1 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        check("ready_before_send", 32'(ready_w[inst]), 32'd1);
        data_r[inst]  = d;
        valid_r[inst] = 1'b1;
        build_frame(inst, d);
        @(posedge clk); #1;
        check("hs_ready_low",  32'(ready_w[inst]), 32'd0);
        check("hs_busy_high",  32'(busy_w[inst]),  32'd1);
        check("hs_start_bit",  32'(out_w[inst]),   32'd0);
        check("hs_baud_en",    32'(en_w[inst]),    32'd1);
        check("hs_done_low",   32'(done_w[inst]),  32'd0);
        check("hs_state",      32'(state_w[inst]), 32'(START));
        if (!hold) valid_r[inst] = 1'b0;
        data_r[inst] = 8'($urandom_range(0, 255));
    endtask

    task automatic check_frame(input int inst, input bit hold);
        int   bitlen = 16 * tick_div;
        int   nbits  = exp_q.size();
        int   good;
        logic exp_b;
        bit   busy_ok  = 1'b1;
        bit   ready_ok = 1'b1;
        bit   done_ok  = 1'b1;
        for (int k = 0; k < nbits; k++) begin
            exp_b = exp_q.pop_front();
            good  = 0;
            for (int c = 0; c < bitlen; c++) begin
                if (out_w[inst] === exp_b) good++;
                if (busy_w[inst] !== 1'b1)  busy_ok  = 1'b0;
                if (ready_w[inst] !== 1'b0) ready_ok = 1'b0;
                if (done_w[inst] !== 1'b0)  done_ok  = 1'b0;
                @(posedge clk); #1;
            end
            check($sformatf("inst%0d_bit%0d_cycles", inst, k), good, bitlen);
        end
        check("frame_busy_high",  32'(busy_ok),  32'd1);
        check("frame_ready_low",  32'(ready_ok), 32'd0 + 32'd1);
        check("frame_no_early_done", 32'(done_ok), 32'd1);
        check("end_done_pulse", 32'(done_w[inst]),  32'd1);
        check("end_busy_low",   32'(busy_w[inst]),  32'd0);
        check("end_ready_high", 32'(ready_w[inst]), 32'd1);
        check("end_baud_en",    32'(en_w[inst]),    32'd0);
        check("end_line_idle",  32'(out_w[inst]),   32'd1);
        check("end_state",      32'(state_w[inst]), 32'(IDLE));
        if (!hold) begin
            @(posedge clk); #1;
            check("done_one_cycle", 32'(done_w[inst]), 32'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < NI; i++) begin
            data_r[i]  = 8'h00;
            valid_r[i] = 1'b0;
        end

        // Reset with the clock stopped: outputs must settle immediately.
        #5 reset = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("rst_tx_out",  32'(out_w[i]),   32'd1);
            check("rst_ready",   32'(ready_w[i]), 32'd1);
            check("rst_baud_en", 32'(en_w[i]),    32'd0);
            check("rst_busy",    32'(busy_w[i]),  32'd0);
            check("rst_done",    32'(done_w[i]),  32'd0);
            check("rst_state",   32'(state_w[i]), 32'(IDLE));
        end
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // 8N1 frame of A5.
        start_frame(0, 8'hA5, 1'b0);
        check_frame(0, 1'b0);

        // Even and odd parity on 07.
        start_frame(1, 8'h07, 1'b0);
        check_frame(1, 1'b0);
        start_frame(2, 8'h07, 1'b0);
        check_frame(2, 1'b0);

        // Two stop bits, tx_valid held across frames: 00 then FF.
        start_frame(3, 8'h00, 1'b1);
        check_frame(3, 1'b1);
        start_frame(3, 8'hFF, 1'b0);
        check_frame(3, 1'b0);

        // Abort during data bit 3 of 3C.
        start_frame(0, 8'h3C, 1'b0);
        repeat (276) @(posedge clk);
        #3;
        check("abort_in_data", 32'(state_w[0]), 32'(DATA));
        check("abort_bit3",    32'(out_w[0]),   32'd1);
        reset = 1'b0;
        #1;
        check("abort_tx_out",  32'(out_w[0]),   32'd1);
        check("abort_baud_en", 32'(en_w[0]),    32'd0);
        check("abort_no_done", 32'(done_w[0]),  32'd0);
        check("abort_busy",    32'(busy_w[0]),  32'd0);
        check("abort_ready",   32'(ready_w[0]), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_after_done", 32'(done_w[0]), 32'd0);
        start_frame(0, 8'($urandom_range(0, 255)), 1'b0);
        check_frame(0, 1'b0);

        // Generator at 50 MHz / 9600 baud / 16x: 325 clocks per tick, 55 payload.
        tick_div = 325;
        start_frame(0, 8'h55, 1'b0);
        n = 0;
        while (done_w[0] !== 1'b1 && n < 60000) begin
            if ((n % 5200) == 2600 && exp_q.size() != 0)
                check("int_bit_center", 32'(out_w[0]), 32'(exp_q.pop_front()));
            @(posedge clk); #1;
            n++;
        end
        check("int_frame_cycles", n, 10 * 16 * 325);
        check("int_line_idle", 32'(out_w[0]), 32'd1);
        tick_div = 4;
        @(posedge clk); #1;

        // Randomized payloads on every configuration.
        for (int i = 0; i < NI; i++) begin
            for (int r = 0; r < 3; r++) begin
                start_frame(i, 8'($urandom_range(0, 255)), 1'b0);
                check_frame(i, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
